// File: rtl/axi2mem_pkg.sv
// Shared types for the AXI-to-TCDM write path: FSM states and beat counter width.
// No logic; constants and typedefs only.
// Not applicable (no handshakes).
package axi2mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_RESP  = 2'd2
    } wr_state_e;

    // Burst length field is beats-minus-one, so 8 bits covers 1..256 beats.
    localparam int BEAT_LEN_W = 8;

endpackage

// File: rtl/axi2mem_tcdm_wr_lane.sv
// One 32-bit TCDM write lane: issues the lane head as a TCDM write, pops it on grant.
// Latency: combinational request/pop from the buffer head; done flag registered.
// Backpressure: holds request (stable addr/data) until granted; empty buffer stalls this lane only.
module axi2mem_tcdm_wr_lane #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  active,
    input  logic                  beat_clr,
    input  logic [ADDR_WIDTH-1:0] lane_addr,
    input  logic [31:0]           pop_dat,
    input  logic [3:0]            pop_strb,
    input  logic                  pop_gnt,
    input  logic                  tcdm_gnt,
    output logic                  pop_req,
    output logic                  tcdm_req,
    output logic [ADDR_WIDTH-1:0] tcdm_add,
    output logic                  tcdm_wen,
    output logic [31:0]           tcdm_wdata,
    output logic [3:0]            tcdm_be,
    output logic                  lane_done
);

    logic done_q;
    logic pending;
    logic skip;

    // Lane still owes a word for this beat and the buffer has one ready.
    assign pending  = active & ~done_q & pop_gnt;
    // Fully masked words carry nothing to memory; drop them without a bus cycle.
    assign skip     = pending & (pop_strb == 4'b0000);
    assign tcdm_req = pending & (pop_strb != 4'b0000);
    assign pop_req  = (tcdm_req & tcdm_gnt) | skip;
    // Includes the finishing cycle so the beat can close the same cycle the last lane pops.
    assign lane_done = done_q | pop_req;

    assign tcdm_add   = tcdm_req ? lane_addr : '0;
    assign tcdm_wen   = ~tcdm_req;
    assign tcdm_wdata = tcdm_req ? pop_dat : 32'h0;
    assign tcdm_be    = tcdm_req ? pop_strb : 4'h0;

    // Track whether this lane has finished the current beat; beat close wins over a late pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else if (beat_clr) begin
            done_q <= 1'b0;
        end else if (pop_req) begin
            done_q <= 1'b1;
        end
    end

endmodule

// File: rtl/axi2mem_tcdm_wr_if.sv
// Burst write engine: turns a burst command into per-beat 2x32-bit TCDM writes, then one response.
// Latency: first TCDM request the cycle after command grant; response the cycle after the last beat.
// Backpressure: command only accepted in IDLE; beats wait on both lanes; response held until ready.
module axi2mem_tcdm_wr_if
    import axi2mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 6
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cmd_req_i,
    output logic                       cmd_gnt_o,
    input  logic [ADDR_WIDTH-1:0]      cmd_addr_i,
    input  logic [7:0]                 cmd_len_i,
    input  logic [ID_WIDTH-1:0]        cmd_id_i,
    input  logic [1:0][31:0]           wr_data_pop_dat_i,
    input  logic [1:0][3:0]            wr_data_pop_strb_i,
    input  logic [1:0]                 wr_data_pop_gnt_i,
    output logic [1:0]                 wr_data_pop_req_o,
    output logic [1:0]                 tcdm_req_o,
    input  logic [1:0]                 tcdm_gnt_i,
    output logic [1:0][ADDR_WIDTH-1:0] tcdm_add_o,
    output logic [1:0]                 tcdm_wen_o,
    output logic [1:0][31:0]           tcdm_wdata_o,
    output logic [1:0][3:0]            tcdm_be_o,
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic [ID_WIDTH-1:0]        resp_id_o
);

    wr_state_e                   state_q;
    logic [ADDR_WIDTH-1:0]       base_q;
    logic [BEAT_LEN_W-1:0]       len_q;
    logic [BEAT_LEN_W-1:0]       beat_q;
    logic [ID_WIDTH-1:0]         id_q;

    logic                        active;
    logic                        beat_done;
    logic [1:0]                  lane_done;
    logic [ADDR_WIDTH-1:0]       beat_off;
    logic [1:0][ADDR_WIDTH-1:0]  lane_addr;

    assign active    = (state_q == ST_BURST);
    assign beat_done = active & lane_done[0] & lane_done[1];
    assign resp_id_o = id_q;

    // Each beat is 8 bytes; address arithmetic wraps naturally at 2^ADDR_WIDTH.
    assign beat_off     = ADDR_WIDTH'(beat_q) << 3;
    assign lane_addr[0] = base_q + beat_off;
    assign lane_addr[1] = base_q + beat_off + ADDR_WIDTH'(4);

    // Command latch, beat sequencing and the registered handshake outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            id_q         <= '0;
            cmd_gnt_o    <= 1'b1;
            resp_valid_o <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_req_i) begin
                        base_q    <= {cmd_addr_i[ADDR_WIDTH-1:3], 3'b000};
                        len_q     <= cmd_len_i;
                        id_q      <= cmd_id_i;
                        beat_q    <= '0;
                        state_q   <= ST_BURST;
                        cmd_gnt_o <= 1'b0;
                    end
                end
                ST_BURST: begin
                    if (beat_done) begin
                        if (beat_q == len_q) begin
                            state_q      <= ST_RESP;
                            resp_valid_o <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        state_q      <= ST_IDLE;
                        resp_valid_o <= 1'b0;
                        cmd_gnt_o    <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    resp_valid_o <= 1'b0;
                    cmd_gnt_o    <= 1'b1;
                end
            endcase
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_lane
        axi2mem_tcdm_wr_lane #(
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_lane (
            .clk        (clk_i),
            .rst_n      (rst_ni),
            .active     (active),
            .beat_clr   (beat_done),
            .lane_addr  (lane_addr[i]),
            .pop_dat    (wr_data_pop_dat_i[i]),
            .pop_strb   (wr_data_pop_strb_i[i]),
            .pop_gnt    (wr_data_pop_gnt_i[i]),
            .tcdm_gnt   (tcdm_gnt_i[i]),
            .pop_req    (wr_data_pop_req_o[i]),
            .tcdm_req   (tcdm_req_o[i]),
            .tcdm_add   (tcdm_add_o[i]),
            .tcdm_wen   (tcdm_wen_o[i]),
            .tcdm_wdata (tcdm_wdata_o[i]),
            .tcdm_be    (tcdm_be_o[i]),
            .lane_done  (lane_done[i])
        );
    end

endmodule
